lsu_mem_port: RTL and testbench
===============================

Name: lsu_mem_port

Overview:
- Parametrised multi-cycle load/store unit. Next generation of the core's memory path, which today handles only a single-cycle 64-bit store.
- Sits between the core execute stage and the data-memory interface.
- Supports byte/half/word/double accesses, signed and unsigned loads, and byte-masked stores.
- Uses valid/ready request handshakes on both sides plus a memory response channel; misaligned accesses are detected without touching memory.

Parameters:
- XLEN, 64, data width; 32 or 64.
- ADDR_W, 64, address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  core request valid.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = B, 1 = H, 2 = W, 3 = D.
- req_unsigned  in  1  zero-extend load result.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, LSB-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- resp_misalign  out  1  access rejected.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W  address aligned down to XLEN/8.
- mem_wdata  out  XLEN  lane-shifted store data.
- mem_wmask  out  XLEN/8  byte enables; 0 for loads.
- mem_resp_valid  in  1  read data or write ack.
- mem_rdata  in  XLEN  full aligned word.

Behaviour:
- Reset:
  - State goes to IDLE immediately on rst high.
  - All outputs 0, except req_ready, which is 1 once rst deasserts.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch we/size/unsigned/addr/wdata.
  - Misaligned means addr not a multiple of 2^size, or size = 3 with XLEN = 32. Misaligned requests go to RESP with the error flag set. All others go to REQ.
- REQ:
  - mem_req_valid = 1.
  - mem_we/addr/wdata/wmask held stable from latched values until mem_req_ready.
  - On mem_req_ready, go to WAIT.
- WAIT:
  - On mem_resp_valid, capture data and go to RESP.
  - mem_resp_valid in any other state is ignored.
  - Response never arrives in the same cycle as acceptance.
- RESP:
  - resp_valid = 1 for exactly one cycle, then IDLE.
  - req_ready = 0 in REQ, WAIT and RESP. No back-to-back overlap.
- Latency:
  - Accept at T; mem_req_valid at T+1.
  - With immediate ready and a one-cycle memory, resp_valid at T+3.
  - Misaligned request: resp_valid at T+1, and mem_req_valid never asserts.
- Store formatting:
  - off = addr mod (XLEN/8).
  - mem_wdata = req_wdata << (8*off).
  - mem_wmask = ((1<<2^size) - 1) << off.
- Load formatting:
  - Compute mem_rdata >> (8*off) and truncate to 2^size bytes.
  - Sign-extend unless req_unsigned. For size = D, req_unsigned is ignored.
  - Stores: resp_rdata = 0; mem_resp_valid acts as the write ack.
- Reset mid-operation:
  - Aborts instantly and drops any outstanding memory transaction.
  - The memory model must tolerate the dropped request; a late mem_resp_valid is ignored.
- Widths: offset uses the low log2(XLEN/8) address bits, with no carry into upper bits.

Decomposition:
- Package lsu_pkg:
  - Size constants SZ_B/SZ_H/SZ_W/SZ_D.
  - State enum {IDLE, REQ, WAIT, RESP}.
  - Function for the misalignment check.
- One sub-module, lsu_align: combinational store shift/mask generation and load shift/extend, parametrised by XLEN.
- Top holds the FSM and request/response registers.

Test Plan:
- ld addr 0x80000008, mem_rdata 0x1122334455667788, mem_req_ready = 1:
  - mem_addr 0x80000008, mem_wmask 0x00.
  - resp_rdata 0x1122334455667788 at T+3.
- lb addr 0x80000003, mem_rdata 0x0000000080000000:
  - resp_rdata 0xFFFFFFFFFFFFFF80.
  - Same access as lbu gives 0x0000000000000080.
- sh addr 0x80000006, wdata 0xABCD:
  - mem_addr 0x80000000, mem_wmask 0xC0, mem_wdata[63:48] = 0xABCD.
  - resp_valid after ack, resp_rdata 0.
- lw addr 0x80000002:
  - resp_valid and resp_misalign at T+1, mem_req_valid stays 0.
  - Same check with XLEN = 32: sd aligned also flags misalign.
- mem_req_ready held 0 for 5 cycles:
  - mem_req_valid stays 1 with address/data/mask stable.
  - req_ready stays 0; completes normally after ready.
- rst pulsed while in WAIT:
  - All outputs 0 in the same cycle.
  - A stale mem_resp_valid afterwards produces no resp_valid.
  - Next request accepted and completes correctly.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and the
// alignment rule applied before any memory request is issued.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } lsu_state_t;

  // A doubleword on a 32-bit datapath cannot be served in one beat, so it is rejected too.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [2:0] addr_lo,
                                         input int unsigned xlen);
    logic mis;
    mis = 1'b0;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = addr_lo[0];
      SZ_W:    mis = |addr_lo[1:0];
      default: mis = (xlen == 32) || (|addr_lo);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering: shifts store data/byte enables into place and extracts,
// then sign- or zero-extends, load data. Purely combinational.
module lsu_align
  import lsu_pkg::*;
#(
  parameter  int XLEN  = 64,
  localparam int NB    = XLEN / 8,
  localparam int OFF_W = $clog2(NB)
) (
  input  logic [1:0]       i_size,
  input  logic             i_ld_unsigned,
  input  logic [OFF_W-1:0] i_off,
  input  logic [XLEN-1:0]  i_st_data,
  input  logic [XLEN-1:0]  i_ld_raw,
  output logic [XLEN-1:0]  o_st_data,
  output logic [NB-1:0]    o_st_mask,
  output logic [XLEN-1:0]  o_ld_data
);

  logic [OFF_W+2:0] w_bit_sh;
  logic [NB-1:0]    w_mask_base;
  logic [XLEN-1:0]  w_shifted;
  logic [XLEN-1:0]  w_keep;
  logic             w_sign;

  assign w_bit_sh  = {i_off, 3'b000};
  assign o_st_data = i_st_data << w_bit_sh;
  assign o_st_mask = w_mask_base << i_off;
  assign w_shifted = i_ld_raw >> w_bit_sh;

  always_comb begin
    w_mask_base = '1;
    w_keep      = '1;
    w_sign      = 1'b0;
    case (i_size)
      SZ_B: begin
        w_mask_base = NB'(1);
        w_keep      = XLEN'(8'hFF);
        w_sign      = w_shifted[7];
      end
      SZ_H: begin
        w_mask_base = NB'(3);
        w_keep      = XLEN'(16'hFFFF);
        w_sign      = w_shifted[15];
      end
      SZ_W: begin
        w_mask_base = NB'(15);
        w_keep      = XLEN'(32'hFFFF_FFFF);
        w_sign      = w_shifted[31];
      end
      default: ;
    endcase
  end

  // Bits above the access width are filled with the sign only for signed loads.
  assign o_ld_data = (w_shifted & w_keep) |
                     ({XLEN{w_sign & ~i_ld_unsigned}} & ~w_keep);

endmodule

// File: rtl/lsu_mem_port.sv
// Multi-cycle load/store port: accept -> mem request at +1, response at +3 with a
// one-cycle memory; one access in flight, req_ready low until the response pulse ends.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                resp_valid,
  output logic [XLEN-1:0]     resp_rdata,
  output logic                resp_misalign,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [XLEN/8-1:0]   mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [XLEN-1:0]     mem_rdata
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  lsu_state_t        r_state;
  lsu_state_t        w_next;

  logic              r_we;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic              r_misalign;
  logic [XLEN-1:0]   r_rdata;

  logic              w_misalign;
  logic              w_take;
  logic              w_in_req;
  logic              w_in_resp;
  logic [XLEN-1:0]   w_st_data;
  logic [NB-1:0]     w_st_mask;
  logic [XLEN-1:0]   w_ld_data;

  assign w_misalign = is_misaligned(req_size, req_addr[2:0], XLEN);
  assign w_take     = (r_state == ST_IDLE) && req_valid;
  assign w_in_req   = (r_state == ST_REQ);
  assign w_in_resp  = (r_state == ST_RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    resp_valid    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = ~rst;
        if (req_valid) w_next = w_misalign ? ST_RESP : ST_REQ;
      end
      ST_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) w_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_resp_valid) w_next = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        w_next     = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we       <= 1'b0;
      r_size     <= SZ_B;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_misalign <= 1'b0;
      r_rdata    <= '0;
    end else if (w_take) begin
      r_we       <= req_we;
      r_size     <= req_size;
      r_unsigned <= req_unsigned;
      r_addr     <= req_addr;
      r_wdata    <= req_wdata;
      r_misalign <= w_misalign;
      r_rdata    <= '0;
    end else if ((r_state == ST_WAIT) && mem_resp_valid) begin
      // For stores the response is only a write ack; no data is returned.
      r_rdata <= r_we ? '0 : w_ld_data;
    end
  end

  lsu_align #(.XLEN(XLEN)) u_align (
    .i_size        (r_size),
    .i_ld_unsigned (r_unsigned),
    .i_off         (r_addr[OFF_W-1:0]),
    .i_st_data     (r_wdata),
    .i_ld_raw      (mem_rdata),
    .o_st_data     (w_st_data),
    .o_st_mask     (w_st_mask),
    .o_ld_data     (w_ld_data)
  );

  assign mem_we        = w_in_req & r_we;
  assign mem_addr      = w_in_req ? {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign mem_wdata     = (w_in_req & r_we) ? w_st_data : '0;
  assign mem_wmask     = (w_in_req & r_we) ? w_st_mask : '0;
  assign resp_rdata    = w_in_resp ? r_rdata : '0;
  assign resp_misalign = w_in_resp & r_misalign;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port: a 64-bit instance plus a 32-bit instance for the
// doubleword rejection case; memory side is driven cycle by cycle from the stimulus.
module tb_lsu_mem_port;

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_misalign;
  logic [63:0] resp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_we, mem_resp_valid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;

  logic        req_valid32, req_ready32, req_we32, req_unsigned32;
  logic [1:0]  req_size32;
  logic [31:0] req_addr32, req_wdata32;
  logic        resp_valid32, resp_misalign32;
  logic [31:0] resp_rdata32;
  logic        mem_req_valid32, mem_req_ready32, mem_we32, mem_resp_valid32;
  logic [31:0] mem_addr32, mem_wdata32, mem_rdata32;
  logic [3:0]  mem_wmask32;

  int n_vec;
  int n_err;

  lsu_mem_port #(.XLEN(64), .ADDR_W(64)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_misalign  (resp_misalign),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata)
  );

  lsu_mem_port #(.XLEN(32), .ADDR_W(32)) u_dut32 (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid32),
    .req_ready      (req_ready32),
    .req_we         (req_we32),
    .req_size       (req_size32),
    .req_unsigned   (req_unsigned32),
    .req_addr       (req_addr32),
    .req_wdata      (req_wdata32),
    .resp_valid     (resp_valid32),
    .resp_rdata     (resp_rdata32),
    .resp_misalign  (resp_misalign32),
    .mem_req_valid  (mem_req_valid32),
    .mem_req_ready  (mem_req_ready32),
    .mem_we         (mem_we32),
    .mem_addr       (mem_addr32),
    .mem_wdata      (mem_wdata32),
    .mem_wmask      (mem_wmask32),
    .mem_resp_valid (mem_resp_valid32),
    .mem_rdata      (mem_rdata32)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%016h expected=0x%016h", tag, obs, exp);
    end
  endtask

  // Full access with immediate mem_req_ready and a one-cycle memory.
  task automatic run_ok(input string tag, input logic we, input logic [1:0] sz,
                        input logic uns, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [63:0] rdata, input logic [63:0] exp_maddr,
                        input logic [63:0] exp_wdata, input logic [7:0] exp_mask,
                        input logic [63:0] exp_rdata);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; mem_req_ready = 1'b1;
    step();
    req_valid = 1'b0;
    chk({tag, ".mem_req_valid"}, 64'(mem_req_valid), 64'd1);
    chk({tag, ".mem_addr"}, mem_addr, exp_maddr);
    chk({tag, ".mem_we"}, 64'(mem_we), 64'(we));
    chk({tag, ".mem_wmask"}, 64'(mem_wmask), 64'(exp_mask));
    if (we) chk({tag, ".mem_wdata"}, mem_wdata, exp_wdata);
    chk({tag, ".req_ready_busy"}, 64'(req_ready), 64'd0);
    step();
    chk({tag, ".mem_req_valid_wait"}, 64'(mem_req_valid), 64'd0);
    chk({tag, ".resp_valid_wait"}, 64'(resp_valid), 64'd0);
    mem_resp_valid = 1'b1; mem_rdata = rdata;
    step();
    mem_resp_valid = 1'b0;
    chk({tag, ".resp_valid"}, 64'(resp_valid), 64'd1);
    chk({tag, ".resp_rdata"}, resp_rdata, exp_rdata);
    chk({tag, ".resp_misalign"}, 64'(resp_misalign), 64'd0);
    step();
    chk({tag, ".resp_valid_drop"}, 64'(resp_valid), 64'd0);
    chk({tag, ".req_ready_back"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1;
    req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
    req_valid32 = 0; req_we32 = 0; req_size32 = 0; req_unsigned32 = 0; req_addr32 = 0;
    req_wdata32 = 0; mem_req_ready32 = 1; mem_resp_valid32 = 0; mem_rdata32 = 0;
    step(); step();

    chk("rst.req_ready", 64'(req_ready), 64'd0);
    chk("rst.resp_valid", 64'(resp_valid), 64'd0);
    chk("rst.mem_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst.resp_rdata", resp_rdata, 64'd0);
    rst = 1'b0;
    step();
    chk("post_rst.req_ready", 64'(req_ready), 64'd1);

    run_ok("ld", 1'b0, 2'd3, 1'b0, 64'h8000_0008, 64'h0, 64'h1122_3344_5566_7788,
           64'h8000_0008, 64'h0, 8'h00, 64'h1122_3344_5566_7788);
    run_ok("lb", 1'b0, 2'd0, 1'b0, 64'h8000_0003, 64'h0, 64'h0000_0000_8000_0000,
           64'h8000_0000, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FF80);
    run_ok("lbu", 1'b0, 2'd0, 1'b1, 64'h8000_0003, 64'h0, 64'h0000_0000_8000_0000,
           64'h8000_0000, 64'h0, 8'h00, 64'h0000_0000_0000_0080);
    run_ok("sh", 1'b1, 2'd1, 1'b0, 64'h8000_0006, 64'h0000_0000_0000_ABCD, 64'h0,
           64'h8000_0000, 64'hABCD_0000_0000_0000, 8'hC0, 64'h0);
    run_ok("lh", 1'b0, 2'd1, 1'b0, 64'h8000_0002, 64'h0, 64'h0000_0000_8001_0000,
           64'h8000_0000, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_8001);
    run_ok("lwu", 1'b0, 2'd2, 1'b1, 64'h8000_0004, 64'h0, 64'h89AB_CDEF_0000_0000,
           64'h8000_0000, 64'h0, 8'h00, 64'h0000_0000_89AB_CDEF);

    // Misaligned word on the 64-bit port and an aligned doubleword on the 32-bit port.
    req_valid = 1; req_we = 0; req_size = 2'd2; req_unsigned = 0; req_addr = 64'h8000_0002;
    req_valid32 = 1; req_we32 = 1; req_size32 = 2'd3; req_addr32 = 32'h0000_0010;
    step();
    req_valid = 0; req_valid32 = 0;
    chk("lw_mis.resp_valid", 64'(resp_valid), 64'd1);
    chk("lw_mis.resp_misalign", 64'(resp_misalign), 64'd1);
    chk("lw_mis.mem_req_valid", 64'(mem_req_valid), 64'd0);
    chk("lw_mis.resp_rdata", resp_rdata, 64'd0);
    chk("sd32_mis.resp_valid", 64'(resp_valid32), 64'd1);
    chk("sd32_mis.resp_misalign", 64'(resp_misalign32), 64'd1);
    chk("sd32_mis.mem_req_valid", 64'(mem_req_valid32), 64'd0);
    step();
    chk("lw_mis.resp_valid_drop", 64'(resp_valid), 64'd0);
    chk("lw_mis.mem_req_valid_after", 64'(mem_req_valid), 64'd0);
    chk("sd32_mis.mem_req_valid_after", 64'(mem_req_valid32), 64'd0);
    chk("lw_mis.req_ready_back", 64'(req_ready), 64'd1);

    // Memory stalls the request for several cycles.
    req_valid = 1; req_we = 1; req_size = 2'd2; req_addr = 64'h8000_0004;
    req_wdata = 64'h0000_0000_DEAD_BEEF; mem_req_ready = 0;
    step();
    req_valid = 0;
    for (int i = 0; i < 5; i++) begin
      chk("stall.mem_req_valid", 64'(mem_req_valid), 64'd1);
      chk("stall.mem_addr", mem_addr, 64'h8000_0000);
      chk("stall.mem_wdata", mem_wdata, 64'hDEAD_BEEF_0000_0000);
      chk("stall.mem_wmask", 64'(mem_wmask), 64'h0000_0000_0000_00F0);
      chk("stall.req_ready", 64'(req_ready), 64'd0);
      step();
    end
    mem_req_ready = 1;
    step();
    chk("stall.mem_req_valid_wait", 64'(mem_req_valid), 64'd0);
    mem_resp_valid = 1;
    step();
    mem_resp_valid = 0;
    chk("stall.resp_valid", 64'(resp_valid), 64'd1);
    chk("stall.resp_rdata", resp_rdata, 64'd0);
    step();
    chk("stall.req_ready_back", 64'(req_ready), 64'd1);

    // Reset while waiting for the memory response.
    req_valid = 1; req_we = 0; req_size = 2'd3; req_addr = 64'h8000_0010; mem_req_ready = 1;
    step();
    req_valid = 0;
    step();
    rst = 1;
    #1;
    chk("rst_wait.req_ready", 64'(req_ready), 64'd0);
    chk("rst_wait.mem_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_wait.mem_addr", mem_addr, 64'd0);
    chk("rst_wait.resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_wait.resp_rdata", resp_rdata, 64'd0);
    step();
    rst = 0;
    step();
    mem_resp_valid = 1; mem_rdata = 64'hCAFE_F00D_CAFE_F00D;
    step();
    mem_resp_valid = 0;
    chk("stale.resp_valid", 64'(resp_valid), 64'd0);
    chk("stale.req_ready", 64'(req_ready), 64'd1);
    step();
    chk("stale.resp_valid_later", 64'(resp_valid), 64'd0);

    run_ok("ld_after_rst", 1'b0, 2'd3, 1'b0, 64'h8000_0018, 64'h0, 64'h0123_4567_89AB_CDEF,
           64'h8000_0018, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
